// File: rtl/cnn_div_24u_13u_seq.sv
// cnn_div_24u_13u_seq: radix-2 restoring divider, saturating quotient, valid/ready on both sides, ce-gated.
module cnn_div_24u_13u_seq #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 13,
    parameter int QUOT_W     = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dbz
);
    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  part_q, part_d;
    logic [DIVIDEND_W-2:0] quo_q, quo_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  ovf_q, ovf_d, dbz_q, dbz_d;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W-1:0]  diff;
    logic [DIVIDEND_W-1:0] qfull;
    logic                  ge, big, zero;

    // The stored partial is always below the divisor, so the subtraction result fits DIVISOR_W bits.
    always_comb begin
        shifted = {part_q, dvd_q[DIVIDEND_W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        diff    = ge ? shifted[DIVISOR_W-1:0] - dvs_q : shifted[DIVISOR_W-1:0];
        qfull   = {quo_q, ge};
        big     = (qfull >> QUOT_W) != '0;
        zero    = dvs_q == '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                dvd_d   = dividend;
                dvs_d   = divisor;
                part_d  = '0;
                quo_d   = '0;
                cnt_d   = CW'(DIVIDEND_W - 1);
            end
            CALC: begin
                part_d = diff;
                quo_d  = qfull[DIVIDEND_W-2:0];
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    dbz_d   = zero;
                    ovf_d   = !zero && big;
                    quot_d  = (zero || big) ? '1 : qfull[QUOT_W-1:0];
                    rem_d   = zero ? '0 : diff;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
endmodule

// File: doc/cnn_div_24u_13u_seq.md
Name: cnn_div_24u_13u_seq

Overview:
- Sequential unsigned restoring divider; the inverse of the CNN datapath's 11u x 13u -> 24u pipelined multiplier.
- Recovers an 11-bit operand from a 24-bit product and a 13-bit divisor.
- Used in requantisation and average-pool scaling stages.
- Radix-2, one quotient bit per cycle; valid/ready handshake on both sides; ce-gated like the other arithmetic cores.

Parameters:
- DIVIDEND_W, 24, dividend width.
- DIVISOR_W, 13, divisor width and remainder width.
- QUOT_W, 11, output quotient width (QUOT_W <= DIVIDEND_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable. When 0, all state and outputs hold and no handshake completes.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- dividend  in  DIVIDEND_W  unsigned dividend.
- divisor  in  DIVISOR_W  unsigned divisor.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  QUOT_W  saturated quotient.
- remainder  out  DIVISOR_W  remainder.
- ovf  out  1  true quotient exceeded QUOT_W bits.
- dbz  out  1  divide by zero.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, dbz=0.
  - Internal registers are cleared and any in-flight operation is discarded.
- FSM states: IDLE, CALC, DONE. All transitions require ce=1.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: latch dividend and divisor, clear the partial remainder (DIVISOR_W+1 bits), load count=DIVIDEND_W-1, go to CALC.
- CALC:
  - in_ready=0.
  - Each ce cycle: shift the next dividend bit (MSB first) into the partial remainder.
  - If partial >= divisor: subtract divisor and shift 1 into the full-width (DIVIDEND_W) quotient; else shift 0.
  - After the iteration with count=0, go to DONE and register the outputs.
- Output registration on CALC -> DONE:
  - ovf=1 if any full-quotient bit above QUOT_W-1 is set.
  - quotient = all-ones if ovf, else the low QUOT_W bits.
  - remainder = final partial remainder (true remainder, also when ovf).
- Divide by zero:
  - Still takes the full latency.
  - Outputs: quotient=all-ones, remainder=0, dbz=1, ovf=0.
- DONE:
  - out_valid=1; quotient, remainder, ovf and dbz are stable until the handshake.
  - On out_ready=1 at an edge: out_valid=0 and go to IDLE. in_ready rises the following cycle; no same-cycle accept.
- Latency: out_valid is high DIVIDEND_W ce-cycles after the accepting edge (24 by default).
- Throughput: at most one operation per DIVIDEND_W+2 ce-cycles.
- ce=0 in any state: freeze the FSM, counter and datapath. Latency counts ce=1 cycles only.
- in_valid during CALC or DONE is ignored; the source must hold its operands until in_ready.
- out_ready while out_valid=0 has no effect.
- Counter width is clog2(DIVIDEND_W).
- Output fields keep their last values after the handshake; they are only meaningful while out_valid=1.

Test Plan:
- Basic: reset, then dividend=1000, divisor=7 -> after 24 cycles out_valid=1, quotient=142, remainder=6, ovf=0, dbz=0.
- Multiplier inverse: dividend=16766977 (2047*8191), divisor=8191 -> quotient=2047, remainder=0, ovf=0. Also loop 200 random a(11b) x b(13b, nonzero) products -> quotient==a, remainder==0.
- Overflow: dividend=100000, divisor=7 -> quotient=2047, remainder=5, ovf=1, dbz=0.
- Divide by zero: dividend=12345, divisor=0 -> after 24 cycles quotient=2047, remainder=0, dbz=1, ovf=0.
- Stall/backpressure:
  - Drop ce for 5 cycles mid-CALC -> out_valid appears at cycle 29 and the result is unchanged.
  - Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout.
  - Then out_ready=1 -> in_ready=1 the next cycle.
  - in_valid asserted during CALC with other operands -> ignored.
- Reset mid-operation: assert reset asynchronously (between edges) at cycle 10 of CALC -> in_ready=1 and out_valid=0 immediately. A new operation of 1000/7 then completes correctly with no residue.
